// File: rtl/mole_array_ctrl.sv
// Multi-channel whack-a-mole controller: NUM_MOLES independent mole lanes, each
// with a private millisecond down-timer, sharing one LFSR for OFF-interval jitter,
// with a cap on simultaneously lit moles and saturating score / miss counters.

// One mole channel: OFF / ON / HIT state plus its own down-timer.
module mole_lane #(
  parameter int TW      = 11,
  parameter int INIT_LD = 50,
  parameter int HIT_LD  = 100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          tick,     // enable & ms_tick
  input  logic          hit,
  input  logic          admit,    // OFF expiry may go ON this cycle
  input  logic [TW-1:0] on_ld,    // ON duration, already nonzero
  input  logic [TW-1:0] off_ld,   // fresh OFF duration, already nonzero
  output logic          off_exp,  // OFF timer expires this cycle
  output logic          hit_evt,  // scored hit this cycle
  output logic          miss_evt, // ON expired without a hit
  output logic          on_next   // lane will be ON after this edge
);
  typedef enum logic [1:0] {S_OFF, S_ON, S_HIT} st_t;

  st_t           st;
  logic [TW-1:0] tmr;
  logic          expire;

  // A state lasts exactly D ticks: the tick that sees timer<=1 is the last one.
  assign expire   = tick && (tmr <= TW'(1));
  assign off_exp  = (st == S_OFF) && expire;
  assign hit_evt  = enable && (st == S_ON) && hit;
  assign miss_evt = (st == S_ON) && expire && !hit;
  assign on_next  = ((st == S_ON) && !hit_evt && !miss_evt) || (off_exp && admit);

  // State and timer; everything holds while paused.
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= S_OFF;
      tmr <= TW'(INIT_LD);
    end else if (enable) begin
      case (st)
        S_OFF: begin
          if (off_exp) begin
            if (admit) begin
              st  <= S_ON;
              tmr <= on_ld;
            end else begin
              tmr <= off_ld;   // refused: stay dark for another interval
            end
          end else if (tick) begin
            tmr <= tmr - TW'(1);
          end
        end
        S_ON: begin
          if (hit_evt) begin
            st  <= S_HIT;
            tmr <= TW'(HIT_LD);
          end else if (miss_evt) begin
            st  <= S_OFF;
            tmr <= off_ld;
          end else if (tick) begin
            tmr <= tmr - TW'(1);
          end
        end
        S_HIT: begin
          if (expire) begin
            st  <= S_OFF;
            tmr <= off_ld;
          end else if (tick) begin
            tmr <= tmr - TW'(1);
          end
        end
        default: begin
          st  <= S_OFF;
          tmr <= off_ld;
        end
      endcase
    end
  end
endmodule

module mole_array_ctrl #(
  parameter int          NUM_MOLES  = 4,
  parameter int          MAX_MS     = 2047,
  parameter int          HIT_MS     = 100,
  parameter int          STAGGER_MS = 50,
  parameter int          MAX_UP     = 2,
  parameter int          SCORE_W    = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int         TW         = $clog2(MAX_MS),
  localparam int         CW         = $clog2(NUM_MOLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ms_tick,
  input  logic                 enable,
  input  logic [TW-1:0]        on_ms,
  input  logic [TW-1:0]        off_base_ms,
  input  logic [NUM_MOLES-1:0] hit,
  input  logic                 clear_score,
  output logic [NUM_MOLES-1:0] led,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic [CW-1:0]        moles_up
);
  localparam int HIT_LD = (HIT_MS == 0) ? 1 : ((HIT_MS > MAX_MS) ? MAX_MS : HIT_MS);

  logic                          tick;
  logic [15:0]                   lfsr;
  logic [15:0]                   lfsr_nxt;
  logic [TW-1:0]                 on_ld;
  logic [NUM_MOLES-1:0][TW-1:0]  off_ld;
  logic [NUM_MOLES-1:0]          off_exp, hit_evt, miss_evt, on_next, admit;
  int                            n_hit, n_miss, n_leave, n_on;
  int                            up_base, n_adm;
  logic [SCORE_W:0]              score_sum, miss_sum;

  assign tick     = enable && ms_tick;
  assign on_ld    = (on_ms == '0) ? TW'(1) : on_ms;
  // Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[14:0], r[15]};
    return r;
  endfunction

  // Per-lane OFF duration: base plus rotated LFSR jitter, saturated, never zero.
  always_comb begin
    logic [15:0]   rot;
    logic [TW:0]   sum;
    logic [TW-1:0] d;
    off_ld = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      rot = rotl16(lfsr, i);
      sum = {1'b0, off_base_ms} + (TW+1)'(rot[7:0]);
      d   = (sum > (TW+1)'(MAX_MS)) ? TW'(MAX_MS) : sum[TW-1:0];
      off_ld[i] = (d == '0) ? TW'(1) : d;
    end
  end

  // Event counts for this cycle (independent of admission).
  always_comb begin
    n_hit   = 0;
    n_miss  = 0;
    n_leave = 0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      n_hit   = n_hit   + int'(hit_evt[i]);
      n_miss  = n_miss  + int'(miss_evt[i]);
      n_leave = n_leave + int'(hit_evt[i] | miss_evt[i]);
    end
  end

  // Admission: OFF expiries go ON lowest index first while under the cap.
  always_comb begin
    up_base = int'(moles_up) - n_leave;
    n_adm   = 0;
    admit   = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      if (off_exp[i] && (up_base + n_adm) < MAX_UP) begin
        admit[i] = 1'b1;
        n_adm    = n_adm + 1;
      end
    end
  end

  // Count of moles that will be ON after this edge.
  always_comb begin
    n_on = 0;
    for (int i = 0; i < NUM_MOLES; i++) n_on = n_on + int'(on_next[i]);
  end

  assign score_sum = {1'b0, score}  + (SCORE_W+1)'(n_hit);
  assign miss_sum  = {1'b0, misses} + (SCORE_W+1)'(n_miss);

  genvar g;
  generate
    for (g = 0; g < NUM_MOLES; g++) begin : g_lane
      localparam int LD_RAW = (g + 1) * STAGGER_MS;
      localparam int LD     = (LD_RAW > MAX_MS) ? MAX_MS : LD_RAW;
      mole_lane #(.TW(TW), .INIT_LD(LD), .HIT_LD(HIT_LD)) u_lane (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .tick     (tick),
        .hit      (hit[g]),
        .admit    (admit[g]),
        .on_ld    (on_ld),
        .off_ld   (off_ld[g]),
        .off_exp  (off_exp[g]),
        .hit_evt  (hit_evt[g]),
        .miss_evt (miss_evt[g]),
        .on_next  (on_next[g])
      );
    end
  endgenerate

  // Shared registers: LFSR, LED bank, up-count, saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr     <= LFSR_SEED;
      led      <= '0;
      score    <= '0;
      misses   <= '0;
      moles_up <= '0;
    end else begin
      if (enable) lfsr <= lfsr_nxt;
      led      <= {NUM_MOLES{enable}} & on_next;
      moles_up <= CW'(n_on);
      if (clear_score) begin
        score  <= '0;
        misses <= '0;
      end else begin
        score  <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        misses <= miss_sum[SCORE_W]  ? '1 : miss_sum[SCORE_W-1:0];
      end
    end
  end
endmodule
